// File: rtl/ahb_slv_arbiter_if.sv
// Bundle of the per-master request/control lines and the arbiter's grant and
// response-steering outputs for one AHB slave port.
interface ahb_slv_arbiter_if #(
  parameter int CHANNEL_NUM = 4
);
  logic [CHANNEL_NUM-1:0]       req;
  logic [CHANNEL_NUM-1:0][1:0]  htrans;
  logic [CHANNEL_NUM-1:0][2:0]  hburst;
  logic [CHANNEL_NUM-1:0]       hmastlock;
  logic                         hreadyout_s;
  logic                         hresp_s;
  logic [CHANNEL_NUM-1:0]       sel;
  logic [CHANNEL_NUM-1:0]       dsel;
  logic [CHANNEL_NUM-1:0]       hready_m;
  logic [CHANNEL_NUM-1:0]       hresp_m;

  // Fabric side: drives master requests and the slave response, observes grants.
  modport master (
    output req, htrans, hburst, hmastlock, hreadyout_s, hresp_s,
    input  sel, dsel, hready_m, hresp_m
  );

  // Arbiter side.
  modport slave (
    input  req, htrans, hburst, hmastlock, hreadyout_s, hresp_s,
    output sel, dsel, hready_m, hresp_m
  );
endinterface

// File: rtl/ahb_slv_arbiter.sv
// Round-robin slave-side arbiter: grants one of CHANNEL_NUM masters, holds the
// grant across locked and burst transfers, and steers HREADY/HRESP back.
module ahb_slv_arbiter #(
  parameter int CHANNEL_NUM = 4
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_slv_arbiter_if.slave bus
);
  localparam int OW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int PW = OW + 1;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;

  localparam logic [CHANNEL_NUM-1:0] ONE_HOT0 = {{(CHANNEL_NUM-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]          LAST_CH  = OW'(CHANNEL_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_BURST = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [CHANNEL_NUM-1:0] sel_q, sel_d;
  logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;

  logic [1:0]             own_trans_s;
  logic [2:0]             own_burst_s;
  logic                   own_lock_s;
  logic                   held_s;
  logic                   burst_live_s;
  logic                   win_found_s;
  logic [OW-1:0]          win_idx_s;
  logic [PW-1:0]          probe_s;
  logic [CHANNEL_NUM-1:0] hready_m_s;
  logic [CHANNEL_NUM-1:0] hresp_m_s;

  // Remaining beats after the first one for fixed-length bursts.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: burst_beats_m1 = 4'd3;
      3'd4, 3'd5: burst_beats_m1 = 4'd7;
      3'd6, 3'd7: burst_beats_m1 = 4'd15;
      default:    burst_beats_m1 = 4'd0;
    endcase
  endfunction

  // Decide whether the current owner keeps the slave past this edge.
  always_comb begin
    own_trans_s = bus.htrans[owner_q];
    own_burst_s = bus.hburst[owner_q];
    own_lock_s  = bus.hmastlock[owner_q];
    held_s      = 1'b0;
    if (state_q != ST_IDLE) begin
      held_s = own_lock_s
             | (((own_trans_s == TR_SEQ) || (own_trans_s == TR_BUSY)) && (own_burst_s == HB_INCR))
             | ((state_q == ST_BURST) && (cnt_q > 4'd1))
             | ((own_trans_s == TR_NONSEQ) && (own_burst_s != HB_SINGLE));
    end else begin
      held_s = 1'b0;
    end
  end

  // Round-robin search starting just after the last owner, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = owner_q;
    probe_s     = '0;
    for (int i = 1; i <= CHANNEL_NUM; i++) begin
      probe_s = {1'b0, owner_q} + PW'(i);
      if (probe_s >= PW'(CHANNEL_NUM)) begin
        probe_s = probe_s - PW'(CHANNEL_NUM);
      end else begin
        probe_s = probe_s;
      end
      if (!win_found_s && bus.req[probe_s[OW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = probe_s[OW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic; nothing moves while the slave stretches the transfer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    dsel_d       = dsel_q;
    burst_live_s = 1'b0;
    if (bus.hreadyout_s) begin
      if (state_q == ST_IDLE) begin
        cnt_d        = 4'd0;
        burst_live_s = 1'b0;
      end else if (bus.hresp_s) begin
        cnt_d        = 4'd0;
        burst_live_s = 1'b0;
      end else if ((own_trans_s == TR_NONSEQ) && (own_burst_s >= 3'd2)) begin
        cnt_d        = burst_beats_m1(own_burst_s);
        burst_live_s = 1'b1;
      end else if ((state_q == ST_BURST) && (own_trans_s == TR_SEQ)) begin
        cnt_d        = cnt_q - 4'd1;
        burst_live_s = (cnt_q != 4'd1);
      end else if (state_q == ST_BURST) begin
        cnt_d        = cnt_q;
        burst_live_s = (cnt_q != 4'd0);
      end else begin
        cnt_d        = cnt_q;
        burst_live_s = 1'b0;
      end

      // A master already on the data bus keeps dsel for exactly this edge.
      dsel_d = ((own_trans_s == TR_NONSEQ) || (own_trans_s == TR_SEQ)) ? sel_q
                                                                         : {CHANNEL_NUM{1'b0}};

      if (held_s) begin
        state_d = burst_live_s ? ST_BURST : ST_OWNED;
      end else if (win_found_s) begin
        state_d = ST_OWNED;
        owner_d = win_idx_s;
        sel_d   = ONE_HOT0 << win_idx_s;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_IDLE;
        sel_d   = {CHANNEL_NUM{1'b0}};
        cnt_d   = 4'd0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, grant and beat-counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      owner_q <= LAST_CH;
      cnt_q   <= 4'd0;
      sel_q   <= {CHANNEL_NUM{1'b0}};
      dsel_q  <= {CHANNEL_NUM{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dsel_q  <= dsel_d;
    end
  end

  // Waiting requesters are stalled; everyone else sees the slave or an idle-ready bus.
  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_resp
    assign hready_m_s[g] = (dsel_q[g] || sel_q[g]) ? bus.hreadyout_s : !bus.req[g];
    assign hresp_m_s[g]  = dsel_q[g] ? bus.hresp_s : 1'b0;
  end

  assign bus.sel      = sel_q;
  assign bus.dsel     = dsel_q;
  assign bus.hready_m = hready_m_s;
  assign bus.hresp_m  = hresp_m_s;

endmodule

// File: tb/tb_ahb_slv_arbiter.sv
// Directed bench for ahb_slv_arbiter with four masters: round robin, bursts,
// wait states, locking, error response and reset in mid-burst.
module tb_ahb_slv_arbiter;
  localparam logic [1:0] IDLE = 2'd0, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, WRAP4 = 3'd2, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [3:0] exp_sel [5];

  ahb_slv_arbiter_if #(.CHANNEL_NUM(4)) bus_if ();

  ahb_slv_arbiter #(.CHANNEL_NUM(4)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic [1:0] m, input logic r, input logic [1:0] t,
                       input logic [2:0] b, input logic l);
    bus_if.req[m]       = r;
    bus_if.htrans[m]    = t;
    bus_if.hburst[m]    = b;
    bus_if.hmastlock[m] = l;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.req         = 4'b0101;
    bus_if.htrans      = '0;
    bus_if.hburst      = '0;
    bus_if.hmastlock   = '0;
    bus_if.hreadyout_s = 1'b1;
    bus_if.hresp_s     = 1'b0;
    tick();
    tick();
    chk("rst_sel",    bus_if.sel,      16'h0);
    chk("rst_dsel",   bus_if.dsel,     16'h0);
    chk("rst_hready", bus_if.hready_m, 16'b1010);
    chk("rst_hresp",  bus_if.hresp_m,  16'h0);
    chk("rst_cnt",    dut.cnt_q,       16'h0);
    rst_n = 1'b1;

    // Everyone requests single transfers: plain rotation from master 0.
    for (int m = 0; m < 4; m++) set_m(2'(m), 1'b1, NONSEQ, SINGLE, 1'b0);
    #1;
    chk("rr_hready_pre", bus_if.hready_m, 16'b0000);
    exp_sel[0] = 4'b0001; exp_sel[1] = 4'b0010; exp_sel[2] = 4'b0100;
    exp_sel[3] = 4'b1000; exp_sel[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_sel",  bus_if.sel,  16'(exp_sel[i]));
      chk("rr_dsel", bus_if.dsel, (i == 0) ? 16'h0 : 16'(exp_sel[i-1]));
    end

    // Master 1 INCR4 while master 2 waits.
    set_m(2'd0, 1'b0, IDLE,   SINGLE, 1'b0);
    set_m(2'd1, 1'b1, NONSEQ, INCR4,  1'b0);
    set_m(2'd2, 1'b1, NONSEQ, SINGLE, 1'b0);
    set_m(2'd3, 1'b0, IDLE,   SINGLE, 1'b0);
    tick();
    chk("b4_grant_sel",  bus_if.sel,  16'b0010);
    chk("b4_grant_dsel", bus_if.dsel, 16'b0000);
    for (int k = 0; k < 4; k++) begin
      bus_if.htrans[1] = (k == 0) ? NONSEQ : SEQ;
      #1;
      chk("b4_sel_hold",  bus_if.sel,         16'b0010);
      chk("b4_hready2",   bus_if.hready_m[2], 16'h0);
      chk("b4_dsel",      bus_if.dsel,        (k == 0) ? 16'b0000 : 16'b0010);
      tick();
    end
    chk("b4_next_sel",  bus_if.sel,  16'b0100);
    chk("b4_next_dsel", bus_if.dsel, 16'b0010);

    // Master 0 INCR8 with three wait states on beat 2.
    set_m(2'd0, 1'b1, NONSEQ, INCR8,  1'b0);
    set_m(2'd1, 1'b0, IDLE,   SINGLE, 1'b0);
    set_m(2'd2, 1'b0, NONSEQ, SINGLE, 1'b0);
    tick();
    chk("b8_grant_sel",  bus_if.sel,  16'b0001);
    chk("b8_grant_dsel", bus_if.dsel, 16'b0100);
    bus_if.htrans[2] = IDLE;
    tick();
    chk("b8_load_cnt",  dut.cnt_q,   16'd7);
    chk("b8_load_dsel", bus_if.dsel, 16'b0001);
    bus_if.htrans[0]   = SEQ;
    set_m(2'd1, 1'b1, NONSEQ, SINGLE, 1'b0);
    bus_if.hreadyout_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b8_stall_hready0", bus_if.hready_m[0], 16'h0);
      chk("b8_stall_hready1", bus_if.hready_m[1], 16'h0);
      tick();
      chk("b8_stall_sel",  bus_if.sel,  16'b0001);
      chk("b8_stall_dsel", bus_if.dsel, 16'b0001);
      chk("b8_stall_cnt",  dut.cnt_q,   16'd7);
    end
    bus_if.hreadyout_s = 1'b1;
    #1;
    chk("b8_resume_hready0", bus_if.hready_m[0], 16'h1);
    tick();
    chk("b8_beat2_cnt", dut.cnt_q, 16'd6);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("b8_run_sel", bus_if.sel, 16'b0001);
      chk("b8_run_cnt", dut.cnt_q,  16'(5 - j));
    end
    tick();
    chk("b8_end_sel",  bus_if.sel,  16'b0010);
    chk("b8_end_dsel", bus_if.dsel, 16'b0001);
    chk("b8_end_cnt",  dut.cnt_q,   16'd0);

    // Master 3 locked singles while master 0 waits.
    set_m(2'd0, 1'b0, IDLE,   SINGLE, 1'b0);
    set_m(2'd1, 1'b0, NONSEQ, SINGLE, 1'b0);
    set_m(2'd3, 1'b1, NONSEQ, SINGLE, 1'b1);
    tick();
    chk("lk_grant_sel", bus_if.sel, 16'b1000);
    bus_if.htrans[1] = IDLE;
    set_m(2'd0, 1'b1, NONSEQ, SINGLE, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("lk_hready0", bus_if.hready_m[0], 16'h0);
      tick();
      chk("lk_sel",  bus_if.sel,  16'b1000);
      chk("lk_dsel", bus_if.dsel, 16'b1000);
    end
    set_m(2'd3, 1'b0, NONSEQ, SINGLE, 1'b0);
    tick();
    chk("lk_release_sel", bus_if.sel, 16'b0001);

    // Master 0 WRAP4 takes an error on beat 2, then goes idle.
    set_m(2'd0, 1'b1, NONSEQ, WRAP4,  1'b0);
    set_m(2'd2, 1'b1, NONSEQ, SINGLE, 1'b0);
    set_m(2'd3, 1'b0, IDLE,   SINGLE, 1'b0);
    tick();
    chk("er_load_cnt", dut.cnt_q,   16'd3);
    chk("er_dsel",     bus_if.dsel, 16'b0001);
    bus_if.htrans[0] = SEQ;
    bus_if.hresp_s   = 1'b1;
    #1;
    chk("er_hresp_m", bus_if.hresp_m, 16'b0001);
    tick();
    chk("er_cnt_clear", dut.cnt_q,  16'd0);
    chk("er_sel",       bus_if.sel, 16'b0001);
    bus_if.hresp_s = 1'b0;
    set_m(2'd0, 1'b0, IDLE, SINGLE, 1'b0);
    #1;
    chk("er_hresp_ok", bus_if.hresp_m, 16'b0000);
    tick();
    chk("er_next_sel",  bus_if.sel,  16'b0100);
    chk("er_next_dsel", bus_if.dsel, 16'b0000);

    // Reset in the middle of master 2's INCR16.
    set_m(2'd0, 1'b1, NONSEQ, SINGLE, 1'b0);
    set_m(2'd2, 1'b1, NONSEQ, INCR16, 1'b0);
    tick();
    chk("r16_load_cnt", dut.cnt_q, 16'd15);
    bus_if.htrans[2] = SEQ;
    tick();
    tick();
    chk("r16_mid_cnt", dut.cnt_q,  16'd13);
    chk("r16_mid_sel", bus_if.sel, 16'b0100);
    rst_n = 1'b0;
    #1;
    chk("r16_rst_sel",    bus_if.sel,      16'h0);
    chk("r16_rst_dsel",   bus_if.dsel,     16'h0);
    chk("r16_rst_cnt",    dut.cnt_q,       16'h0);
    chk("r16_rst_hready", bus_if.hready_m, 16'b1010);
    tick();
    rst_n = 1'b1;
    set_m(2'd2, 1'b1, NONSEQ, SINGLE, 1'b0);
    tick();
    chk("r16_first_sel", bus_if.sel, 16'b0001);

    // No requests: drop to IDLE, then resume after the retained last owner.
    for (int m = 0; m < 4; m++) set_m(2'(m), 1'b0, IDLE, SINGLE, 1'b0);
    tick();
    chk("nr_sel",  bus_if.sel,  16'h0);
    chk("nr_dsel", bus_if.dsel, 16'h0);
    for (int m = 0; m < 4; m++) set_m(2'(m), 1'b1, NONSEQ, SINGLE, 1'b0);
    tick();
    chk("nr_resume_sel", bus_if.sel, 16'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slv_arbiter.md
AHB_SLV_ARBITER -- requirements
Module: ahb_slv_arbiter

Interface
REQ-001 Parameter CHANNEL_NUM, default 4: number of master channels competing for this slave; legal range 2-16.
REQ-002 HCLK  input  1  single clock; all state updates on rising edge.
REQ-003 HRESETn  input  1  asynchronous, active-low reset.
REQ-004 req  input  [CHANNEL_NUM-1:0]  per-master decoder hit for this slave in the current address phase.
REQ-005 htrans  input  [CHANNEL_NUM-1:0][1:0]  per-master HTRANS: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-006 hburst  input  [CHANNEL_NUM-1:0][2:0]  per-master HBURST: SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7.
REQ-007 hmastlock  input  [CHANNEL_NUM-1:0]  per-master lock request.
REQ-008 hreadyout_s  input  1  slave HREADYOUT.
REQ-009 hresp_s  input  1  slave HRESP; 1 = ERROR.
REQ-010 sel  output  [CHANNEL_NUM-1:0]  registered one-hot address-phase grant; drives the master-to-slave payload mux select.
REQ-011 dsel  output  [CHANNEL_NUM-1:0]  registered one-hot data-phase owner; selects which master receives the slave response.
REQ-012 hready_m  output  [CHANNEL_NUM-1:0]  per-master HREADY.
REQ-013 hresp_m  output  [CHANNEL_NUM-1:0]  per-master HRESP.

Function
REQ-014 The block SHALL implement the states IDLE (no owner), OWNED (owner, no counted burst) and BURST (owner, beat counter active).
REQ-015 All state, sel, dsel, owner pointer and beat counter SHALL update only on edges where hreadyout_s=1; when hreadyout_s=0 they SHALL hold.
REQ-016 An arbitration point SHALL be an update edge in IDLE, or in OWNED/BURST when the owner is not held.
REQ-017 The owner is held when: hmastlock[owner]=1; or htrans[owner] is SEQ/BUSY with hburst=INCR; or BURST with beat counter greater than 1; or htrans[owner]=NONSEQ with hburst not SINGLE.
REQ-018 Arbitration SHALL be round-robin, searching req from (last owner+1) mod CHANNEL_NUM upward with wrap-around; the winner gets sel one-hot on the next cycle.
REQ-019 If no req is set at an arbitration point, the next state SHALL be IDLE with sel=0; the last-owner pointer SHALL be retained.
REQ-020 On an update edge with htrans[owner]=NONSEQ and hburst fixed-length (2-7), the block SHALL load the beat counter with 4/8/16 minus 1 and enter BURST.
REQ-021 In BURST, each update edge with htrans[owner]=SEQ SHALL decrement the counter; BUSY SHALL not decrement; reaching 0 SHALL release the owner at that edge (next state OWNED or IDLE per arbitration).
REQ-022 On an update edge with hresp_s=1, the beat counter SHALL clear to 0 and state BURST SHALL fall back to OWNED.
REQ-023 On every update edge, dsel SHALL be loaded with sel if htrans[owner] is NONSEQ or SEQ, otherwise with 0.
REQ-024 hready_m[i] SHALL be: hreadyout_s if dsel[i]=1; else hreadyout_s if sel[i]=1; else 0 if req[i]=1; else 1.
REQ-025 hresp_m[i] SHALL equal hresp_s when dsel[i]=1, otherwise 0 (OKAY).
REQ-026 At most one bit of sel and at most one bit of dsel SHALL be set in any cycle.
REQ-027 Grant latency from req rising in IDLE with hreadyout_s=1 SHALL be exactly one cycle.
REQ-028 A master that loses the grant while still in its data phase SHALL keep dsel until the next update edge.

Reset
REQ-029 While HRESETn=0: state=IDLE, sel=0, dsel=0, beat counter=0, last-owner pointer=CHANNEL_NUM-1 (first priority to master 0).
REQ-030 After reset, hready_m SHALL be 1 for non-requesting masters and 0 for requesting ones; hresp_m SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL immediately clear sel/dsel with no completion of the burst.

Verification
REQ-032 Reset release, req=4'b1111, all NONSEQ SINGLE, hreadyout_s=1 -> sel sequence 0001,0010,0100,1000,0001; dsel trails sel by one cycle.
REQ-033 Master 1 INCR4 (NONSEQ then 3 SEQ), master 2 requesting -> sel=0010 for 4 beats, then 0100; hready_m[2]=0 throughout.
REQ-034 hreadyout_s=0 for 3 cycles during master 0 beat 2 of INCR8 -> sel, dsel and counter frozen; hready_m[0]=0 for those cycles.
REQ-035 Master 3 hmastlock=1, SINGLE transfers for 5 cycles, master 0 requesting -> sel stays 1000 until lock drops, then 0001.
REQ-036 hresp_s=1 with hreadyout_s=1 on beat 2 of master 0 WRAP4, master 0 then IDLE -> counter cleared, hresp_m=0001 for that cycle, grant moves to next requester.
REQ-037 Assert HRESETn=0 mid INCR16 -> sel=0, dsel=0 in the same cycle; after release, master 0 wins first.
